// File: rtl/shift_reg_univ_if.sv
// Command/status bundle for shift_reg_univ: the master drives the command
// fields, the slave (the register) drives the status fields.
interface shift_reg_univ_if #(
  parameter int WIDTH = 9,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             en;
  logic [2:0]       mode;
  logic             si;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             so;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             zero;

  modport master (output en, mode, si, d, input q, so, cnt, done, zero);
  modport slave  (input en, mode, si, d, output q, so, cnt, done, zero);
endinterface

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with shift/rotate/arithmetic modes,
// parallel load, synchronous zeroing and a saturating shift counter.
module shift_reg_univ #(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              clr,
  shift_reg_univ_if.slave  bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_LOAD = 3'd5,
    M_ZERO = 3'd6,
    M_ASR  = 3'd7
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_so_nxt;
  logic             w_shift;
  logic             w_cnt_clr;

  assign w_mode = mode_e'(bus.mode);

  always_comb begin
    w_q_nxt   = r_q;
    w_so_nxt  = r_so;
    w_shift   = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (w_mode)
      M_HOLD: ;
      M_SHL: begin
        w_q_nxt  = {r_q[WIDTH-2:0], bus.si};
        w_so_nxt = r_q[WIDTH-1];
        w_shift  = 1'b1;
      end
      M_SHR: begin
        w_q_nxt  = {bus.si, r_q[WIDTH-1:1]};
        w_so_nxt = r_q[0];
        w_shift  = 1'b1;
      end
      M_ROL: begin
        w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_so_nxt = r_q[WIDTH-1];
        w_shift  = 1'b1;
      end
      M_ROR: begin
        w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
        w_so_nxt = r_q[0];
        w_shift  = 1'b1;
      end
      M_LOAD: begin
        w_q_nxt   = bus.d;
        w_cnt_clr = 1'b1;
      end
      M_ZERO: begin
        w_q_nxt   = '0;
        w_so_nxt  = 1'b0;
        w_cnt_clr = 1'b1;
      end
      M_ASR: begin
        w_q_nxt  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_so_nxt = r_q[0];
        w_shift  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q    <= RESET_VAL;
      r_so   <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.en) begin
        r_q  <= w_q_nxt;
        r_so <= w_so_nxt;
        // done fires only on the WIDTH-1 -> WIDTH step; saturation blocks repeats
        if (w_cnt_clr) begin
          r_cnt <= '0;
        end else if (w_shift && (r_cnt < CW'(WIDTH))) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.so   = r_so;
  assign bus.cnt  = r_cnt;
  assign bus.done = r_done;
  assign bus.zero = (r_q == '0);

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; successor to the fixed 9-bit serial-in shift register.
- Adds a configurable width and a configurable reset value.
- Supports left/right shift, rotate, arithmetic shift, parallel load and synchronous zeroing.
- Includes a shift counter with a one-cycle done pulse so it can act as a serialiser/deserialiser in the xst test designs.

Parameters:
- WIDTH, 9, register width in bits; legal range 2..64.
- RESET_VAL, 0, value of q after clr (WIDTH bits).
- CW, $clog2(WIDTH+1), width of the shift counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- en  input  1  operation enable; 0 = hold everything
- mode  input  3  operation select (see Behaviour)
- si  input  1  serial input
- d  input  WIDTH  parallel load data
- q  output  WIDTH  register contents
- so  output  1  registered copy of the last bit shifted out
- cnt  output  CW  shifts/rotates since last load/zero; saturates at WIDTH
- done  output  1  one-cycle pulse when cnt reaches WIDTH
- zero  output  1  combinational, 1 when q == 0

Behaviour:
- All state updates on the rising clk edge; there are no asynchronous paths.
- Reset: clr=1 at an edge gives q=RESET_VAL, so=0, cnt=0, done=0, regardless of en or mode.
- clr has priority over everything.
- en=0 (and clr=0): q, so and cnt hold; done=0.
- en=1, per mode:
  - 0 HOLD: q holds, cnt holds.
  - 1 SHL: q <= {q[W-2:0], si}; so <= q[W-1].
  - 2 SHR: q <= {si, q[W-1:1]}; so <= q[0].
  - 3 ROL: q <= {q[W-2:0], q[W-1]}; so <= q[W-1].
  - 4 ROR: q <= {q[0], q[W-1:1]}; so <= q[0].
  - 5 LOAD: q <= d; cnt <= 0; so holds.
  - 6 ZERO: q <= 0; cnt <= 0; so <= 0.
  - 7 ASR: q <= {q[W-1], q[W-1:1]}; so <= q[0]; si is ignored.
- Shift modes are 1, 2, 3, 4 and 7. Each one executed increments cnt by 1 when cnt < WIDTH; at cnt == WIDTH it holds (saturates).
- done=1 for exactly one cycle: the cycle after the edge where cnt goes WIDTH-1 -> WIDTH. No further pulses until cnt is cleared by LOAD, ZERO or clr.
- done is registered; it is 0 in every cycle not described above.
- A LOAD or ZERO on the same edge that would have completed the count clears cnt; done stays 0.
- so changes only on shift modes and ZERO (and clr).
- zero tracks q combinationally, including straight after clr when RESET_VAL=0.
- clr asserted mid-sequence (cnt partial) aborts it: cnt=0 and no done pulse.
- Latency: q, so, cnt and done are valid 1 cycle after the command edge; zero has 0 cycles of latency relative to q.
- Arithmetic is unsigned for cnt. No wrap of cnt: saturation is mandatory.

Test Plan:
- Reset (WIDTH=9, RESET_VAL=9'h0A5): clr=1 for 2 cycles with en=1, mode=1 -> q=0A5, so=0, cnt=0, done=0; clr=0, en=0 for 3 cycles -> q stays 0A5.
- Serial fill: ZERO, then SHL 9 times with si=1,1,0,0,1,1,0,0,1 -> q=9'b110011001. cnt steps 1..9; done=1 only in the cycle after the 9th shift. A 10th SHL leaves cnt=9 with done=0, and so=1 (old MSB).
- Parallel-to-serial: LOAD d=9'h1B3, then SHR x9 with si=0 -> so sequence is 1,1,0,0,1,1,0,1,1 (LSB first); final q=0, zero=1, single done pulse.
- Rotate/ASR: LOAD 9'h101; ROL -> 9'h003, so=1; ROR -> 9'h101; ASR x2 -> 9'h1C0 (sign bit replicated), so=1 then 0.
- Enable/priority: mid-sequence (cnt=4) drop en for 3 cycles -> q and cnt frozen. Assert clr together with en=1, mode=5 -> q=RESET_VAL, cnt=0, and no done pulse afterwards.
- Load at boundary: with cnt=8, LOAD at the 9th edge -> cnt=0, done stays 0, q=d.
